// File: rtl/axi_lite_ram_slave_if.sv
// AXI4-Lite bus bundle between a single master and the RAM responder.
// The master modport drives addresses, data and ready-for-response signals.
interface axi_lite_ram_slave_if;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;

    modport master (
        output axi_araddr, axi_arvalid, axi_rready,
        output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
        input  axi_arready, axi_rdata, axi_rresp, axi_rvalid,
        input  axi_awready, axi_wready, axi_bresp, axi_bvalid
    );

    modport slave (
        input  axi_araddr, axi_arvalid, axi_rready,
        input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
        output axi_arready, axi_rdata, axi_rresp, axi_rvalid,
        output axi_awready, axi_wready, axi_bresp, axi_bvalid
    );
endinterface

// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite responder over a word-addressed RAM with byte strobes.
// One transaction in flight at a time; a single FSM serializes reads and writes.
module axi_lite_ram_slave #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_lite_ram_slave_if.slave  axi
);
    localparam int         DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_RESP, WR_ADDR, WR_DATA, WR_RESP
    } state_t;

    state_t state;

    logic [3:0][7:0]       mem [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [ADDR_WIDTH-1:0] aw_idx;
    logic                  rd_hit;
    logic                  aw_hit;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic                  wr_hit;
    logic                  wr_en;
    logic                  unused_addr_lsbs;

    assign rd_idx = axi.axi_araddr[ADDR_WIDTH+1:2];
    assign aw_idx = axi.axi_awaddr[ADDR_WIDTH+1:2];
    assign rd_hit = (axi.axi_araddr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign aw_hit = (axi.axi_awaddr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

    // Byte offset within a word carries no meaning for a word RAM.
    assign unused_addr_lsbs = ^{axi.axi_araddr[1:0], axi.axi_awaddr[1:0]};

    // The commit happens on the W handshake edge, so bvalid never precedes the data.
    assign wr_en = (state == WR_DATA) && axi.axi_wvalid && axi.axi_wready && wr_hit;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && axi.axi_wstrb[i]) mem[wr_idx][i] <= axi.axi_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            axi.axi_arready <= 1'b0;
            axi.axi_awready <= 1'b0;
            axi.axi_wready  <= 1'b0;
            axi.axi_rvalid  <= 1'b0;
            axi.axi_bvalid  <= 1'b0;
            axi.axi_rdata   <= '0;
            axi.axi_rresp   <= OKAY;
            axi.axi_bresp   <= OKAY;
            wr_idx          <= '0;
            wr_hit          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Reads take priority; a pending awvalid simply waits.
                    if (axi.axi_arvalid) begin
                        axi.axi_arready <= 1'b1;
                        state           <= RD_ADDR;
                    end else if (axi.axi_awvalid) begin
                        axi.axi_awready <= 1'b1;
                        state           <= WR_ADDR;
                    end
                end
                RD_ADDR: begin
                    axi.axi_arready <= 1'b0;
                    axi.axi_rdata   <= rd_hit ? mem[rd_idx] : '0;
                    axi.axi_rresp   <= rd_hit ? OKAY : SLVERR;
                    axi.axi_rvalid  <= 1'b1;
                    state           <= RD_RESP;
                end
                RD_RESP: begin
                    if (axi.axi_rready) begin
                        axi.axi_rvalid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                WR_ADDR: begin
                    axi.axi_awready <= 1'b0;
                    wr_idx          <= aw_idx;
                    wr_hit          <= aw_hit;
                    axi.axi_wready  <= 1'b1;
                    state           <= WR_DATA;
                end
                WR_DATA: begin
                    if (axi.axi_wvalid) begin
                        axi.axi_wready <= 1'b0;
                        axi.axi_bresp  <= wr_hit ? OKAY : SLVERR;
                        axi.axi_bvalid <= 1'b1;
                        state          <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi.axi_bready) begin
                        axi.axi_bvalid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Randomized self-checking bench for axi_lite_ram_slave against an associative-array RAM model.
module tb_axi_lite_ram_slave;
    localparam int          AW   = 12;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_lite_ram_slave_if bus ();
    axi_lite_ram_slave #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (.clk(clk), .rst(rst), .axi(bus));

    int checks   = 0;
    int failures = 0;
    logic [31:0] model [int];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % (1 << AW));
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
        for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        model[widx(a)] = w;
    endfunction

    function automatic logic [36:0] out_vec();
        return {bus.axi_arready, bus.axi_awready, bus.axi_wready, bus.axi_rvalid, bus.axi_bvalid,
                bus.axi_rdata};
    endfunction

    task automatic do_read(input logic [31:0] a, input int hold, output logic [31:0] d,
                           output logic [1:0] r, output int lat, output bit stable);
        int n;
        n = 0; lat = 0; stable = 1'b1; d = '0; r = '0;
        bus.axi_araddr = a; bus.axi_arvalid = 1'b1;
        do begin tick(); lat++; n++; end while (!bus.axi_arready && n < 20);
        tick(); lat++;
        bus.axi_arvalid = 1'b0;
        while (!bus.axi_rvalid && n < 20) begin tick(); lat++; n++; end
        if (n >= 20) begin
            checks++; failures++;
            $display("FAIL rd_timeout addr=%h waited=%0d limit=20", a, n);
            return;
        end
        d = bus.axi_rdata; r = bus.axi_rresp;
        repeat (hold) begin
            tick();
            if (!bus.axi_rvalid || bus.axi_rdata !== d || bus.axi_rresp !== r) stable = 1'b0;
        end
        bus.axi_rready = 1'b1;
        tick();
        bus.axi_rready = 1'b0;
        if (bus.axi_rvalid) stable = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] data, input logic [3:0] strb,
                            input int wdelay, input int hold, output logic [1:0] resp,
                            output int blat, output bit stable);
        int n;
        n = 0; blat = 0; stable = 1'b1; resp = '0;
        bus.axi_awaddr = a; bus.axi_awvalid = 1'b1;
        do begin tick(); n++; end while (!bus.axi_awready && n < 20);
        tick();
        bus.axi_awvalid = 1'b0;
        while (!bus.axi_wready && n < 20) begin tick(); n++; end
        if (n >= 20) begin
            checks++; failures++;
            $display("FAIL wr_timeout addr=%h waited=%0d limit=20", a, n);
            return;
        end
        repeat (wdelay) begin
            tick();
            if (!bus.axi_wready || bus.axi_bvalid) stable = 1'b0;
        end
        bus.axi_wdata = data; bus.axi_wstrb = strb; bus.axi_wvalid = 1'b1;
        tick();
        bus.axi_wvalid = 1'b0;
        while (!bus.axi_bvalid && blat < 20) begin tick(); blat++; end
        if (bus.axi_wready) stable = 1'b0;
        resp = bus.axi_bresp;
        repeat (hold) begin
            tick();
            if (!bus.axi_bvalid || bus.axi_bresp !== resp) stable = 1'b0;
        end
        bus.axi_bready = 1'b1;
        tick();
        bus.axi_bready = 1'b0;
        if (bus.axi_bvalid) stable = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (out_vec() !== 37'h0 || bus.axi_rresp !== 2'b00 || bus.axi_bresp !== 2'b00) begin
            failures++;
            $display("FAIL reset_outputs got=%h rresp=%b bresp=%b exp=0", out_vec(), bus.axi_rresp, bus.axi_bresp);
        end
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if ({bus.axi_arready, bus.axi_awready, bus.axi_wready} !== 3'b000) begin
                failures++;
                $display("FAIL idle_ready got=%b exp=000", {bus.axi_arready, bus.axi_awready, bus.axi_wready});
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] d; logic [1:0] r; int lat; bit st;
        do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, r, lat, st);
        model_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
        checks++;
        if (r !== 2'b00 || lat !== 0) begin
            failures++; $display("FAIL basic_wr bresp=%b blat=%0d exp bresp=00 blat=0", r, lat);
        end
        do_read(BASE + 32'h10, 0, d, r, lat, st);
        checks++;
        if (d !== 32'hDEAD_BEEF || r !== 2'b00) begin
            failures++; $display("FAIL basic_rd got=%h/%b exp=deadbeef/00", d, r);
        end
        checks++;
        if (lat !== 2) begin
            failures++; $display("FAIL rd_latency got=%0d exp=2", lat);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] d; logic [1:0] r; int lat; bit st;
        do_write(BASE + 32'h13, 32'h1122_3344, 4'b0101, 0, 0, r, lat, st);
        checks++;
        if (r !== 2'b00) begin failures++; $display("FAIL strb_bresp got=%b exp=00", r); end
        do_read(BASE + 32'h10, 0, d, r, lat, st);
        checks++;
        if (d !== 32'hDE22_BE44) begin failures++; $display("FAIL strb_rd got=%h exp=de22be44", d); end
        model_write(BASE + 32'h13, 32'h1122_3344, 4'b0101);
        do_write(BASE + 32'h10, 32'hFFFF_FFFF, 4'b0000, 0, 0, r, lat, st);
        checks++;
        if (r !== 2'b00) begin failures++; $display("FAIL strb0_bresp got=%b exp=00", r); end
        do_read(BASE + 32'h10, 0, d, r, lat, st);
        checks++;
        if (d !== 32'hDE22_BE44) begin failures++; $display("FAIL strb0_rd got=%h exp=de22be44", d); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d; logic [1:0] r; int lat; bit st;
        do_write(32'h0000_0010, 32'h0, 4'hF, 0, 0, r, lat, st);
        checks++;
        if (r !== 2'b10) begin failures++; $display("FAIL oor_bresp got=%b exp=10", r); end
        do_read(BASE + 32'h10, 0, d, r, lat, st);
        checks++;
        if (d !== model[widx(BASE + 32'h10)] || r !== 2'b00) begin
            failures++; $display("FAIL oor_ram_kept got=%h/%b exp=%h/00", d, r, model[widx(BASE + 32'h10)]);
        end
        do_read(32'h8000_4000, 0, d, r, lat, st);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin failures++; $display("FAIL oor_rd_hi got=%h/%b exp=0/10", d, r); end
        do_read(32'h0000_0010, 0, d, r, lat, st);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin failures++; $display("FAIL oor_rd_lo got=%h/%b exp=0/10", d, r); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d; logic [1:0] r; int lat; bit st;
        bus.axi_araddr = BASE + 32'h10; bus.axi_arvalid = 1'b1;
        bus.axi_awaddr = BASE + 32'h20; bus.axi_awvalid = 1'b1;
        tick();
        checks++;
        if ({bus.axi_arready, bus.axi_awready} !== 2'b10) begin
            failures++; $display("FAIL sim_first got ar/aw=%b exp=10", {bus.axi_arready, bus.axi_awready});
        end
        tick();
        bus.axi_arvalid = 1'b0;
        checks++;
        if (!bus.axi_rvalid || bus.axi_awready || bus.axi_rdata !== model[widx(BASE + 32'h10)] || bus.axi_rresp !== 2'b00) begin
            failures++; $display("FAIL sim_rd rvalid=%b awready=%b rdata=%h rresp=%b exp 1/0/%h/00",
                                 bus.axi_rvalid, bus.axi_awready, bus.axi_rdata, bus.axi_rresp, model[widx(BASE + 32'h10)]);
        end
        bus.axi_rready = 1'b1;
        tick();
        bus.axi_rready = 1'b0;
        checks++;
        if (bus.axi_awready || bus.axi_rvalid) begin
            failures++; $display("FAIL sim_gap awready=%b rvalid=%b exp=0/0", bus.axi_awready, bus.axi_rvalid);
        end
        tick();
        checks++;
        if (!bus.axi_awready) begin failures++; $display("FAIL sim_aw awready=%b exp=1", bus.axi_awready); end
        tick();
        bus.axi_awvalid = 1'b0;
        bus.axi_wdata = 32'hA5A5_5A5A; bus.axi_wstrb = 4'hF; bus.axi_wvalid = 1'b1;
        tick();
        bus.axi_wvalid = 1'b0;
        checks++;
        if (!bus.axi_bvalid || bus.axi_bresp !== 2'b00) begin
            failures++; $display("FAIL sim_b bvalid=%b bresp=%b exp=1/00", bus.axi_bvalid, bus.axi_bresp);
        end
        bus.axi_bready = 1'b1;
        tick();
        bus.axi_bready = 1'b0;
        model_write(BASE + 32'h20, 32'hA5A5_5A5A, 4'hF);
        do_read(BASE + 32'h20, 0, d, r, lat, st);
        checks++;
        if (d !== 32'hA5A5_5A5A || r !== 2'b00) begin
            failures++; $display("FAIL sim_rdback got=%h/%b exp=a5a55a5a/00", d, r);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic [1:0] r; int lat; bit st;
        do_read(BASE + 32'h20, 5, d, r, lat, st);
        checks++;
        if (!st || d !== 32'hA5A5_5A5A) begin failures++; $display("FAIL rd_hold stable=%b rdata=%h exp=1/a5a55a5a", st, d); end
        do_write(BASE + 32'h24, 32'h0BAD_F00D, 4'hF, 3, 5, r, lat, st);
        model_write(BASE + 32'h24, 32'h0BAD_F00D, 4'hF);
        checks++;
        if (!st || lat !== 0 || r !== 2'b00) begin
            failures++; $display("FAIL wr_hold stable=%b blat=%0d bresp=%b exp=1/0/00", st, lat, r);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] r; int lat; bit st; int n;
        bus.axi_araddr = BASE + 32'h10; bus.axi_arvalid = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!bus.axi_rvalid && n < 20);
        bus.axi_arvalid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_vec() !== 37'h0 || bus.axi_rresp !== 2'b00 || bus.axi_bresp !== 2'b00) begin
            failures++; $display("FAIL rst_rd_outputs got=%h exp=0 (waited=%0d)", out_vec(), n);
        end
        tick();
        rst = 1'b0;
        do_read(BASE + 32'h10, 0, d, r, lat, st);
        checks++;
        if (d !== model[widx(BASE + 32'h10)] || r !== 2'b00) begin
            failures++; $display("FAIL rst_rd_after got=%h/%b exp=%h/00", d, r, model[widx(BASE + 32'h10)]);
        end
        bus.axi_awaddr = BASE + 32'h10; bus.axi_awvalid = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!bus.axi_wready && n < 20);
        bus.axi_awvalid = 1'b0;
        bus.axi_wdata = 32'hFFFF_FFFF; bus.axi_wstrb = 4'hF;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_vec() !== 37'h0 || bus.axi_bresp !== 2'b00) begin
            failures++; $display("FAIL rst_wr_outputs got=%h exp=0 (waited=%0d)", out_vec(), n);
        end
        bus.axi_wvalid = 1'b1;
        tick();
        bus.axi_wvalid = 1'b0;
        rst = 1'b0;
        tick();
        do_read(BASE + 32'h10, 0, d, r, lat, st);
        checks++;
        if (d !== model[widx(BASE + 32'h10)]) begin
            failures++; $display("FAIL rst_wr_kept got=%h exp=%h", d, model[widx(BASE + 32'h10)]);
        end
        do_write(BASE + 32'h10, 32'h1357_9BDF, 4'hF, 0, 0, r, lat, st);
        model_write(BASE + 32'h10, 32'h1357_9BDF, 4'hF);
        do_read(BASE + 32'h10, 0, d, r, lat, st);
        checks++;
        if (d !== 32'h1357_9BDF || r !== 2'b00) begin
            failures++; $display("FAIL rst_wr_after got=%h/%b exp=13579bdf/00", d, r);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, a, wd, ua; logic [1:0] r; logic [3:0] s; int lat; bit st; int op;
        int idxs [6];
        for (int i = 0; i < 6; i++) begin
            idxs[i] = int'($urandom_range(0, (1 << AW) - 1));
            a = BASE | (32'(idxs[i]) << 2);
            wd = $urandom;
            do_write(a, wd, 4'hF, 0, 0, r, lat, st);
            model_write(a, wd, 4'hF);
        end
        for (int k = 0; k < 60; k++) begin
            op = int'($urandom_range(0, 9));
            a  = BASE | (32'(idxs[$urandom_range(0, 5)]) << 2) | 32'($urandom_range(0, 3));
            ua = $urandom;
            ua[13:0] = a[13:0];
            if (ua[31:14] == BASE[31:14]) ua[31] = ~ua[31];
            if (op < 4) begin
                do_read(a, int'($urandom_range(0, 2)), d, r, lat, st);
                checks++;
                if (d !== model[widx(a)] || r !== 2'b00 || !st || lat !== 2) begin
                    failures++; $display("FAIL rnd_rd k=%0d addr=%h got=%h/%b st=%b lat=%0d exp=%h/00",
                                         k, a, d, r, st, lat, model[widx(a)]);
                end
            end else if (op < 8) begin
                wd = $urandom; s = 4'($urandom);
                do_write(a, wd, s, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), r, lat, st);
                model_write(a, wd, s);
                checks++;
                if (r !== 2'b00 || !st || lat !== 0) begin
                    failures++; $display("FAIL rnd_wr k=%0d addr=%h bresp=%b st=%b blat=%0d exp=00/1/0", k, a, r, st, lat);
                end
            end else if (op == 8) begin
                do_write(ua, $urandom, 4'hF, 0, 0, r, lat, st);
                checks++;
                if (r !== 2'b10) begin failures++; $display("FAIL rnd_oor_wr k=%0d addr=%h bresp=%b exp=10", k, ua, r); end
            end else begin
                do_read(ua, 0, d, r, lat, st);
                checks++;
                if (d !== 32'h0 || r !== 2'b10) begin
                    failures++; $display("FAIL rnd_oor_rd k=%0d addr=%h got=%h/%b exp=0/10", k, ua, d, r);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.axi_araddr = '0; bus.axi_arvalid = 1'b0; bus.axi_rready = 1'b0;
        bus.axi_awaddr = '0; bus.axi_awvalid = 1'b0;
        bus.axi_wdata  = '0; bus.axi_wstrb   = '0;   bus.axi_wvalid = 1'b0;
        bus.axi_bready = 1'b0;
        test_reset();
        test_basic();
        test_strobe();
        test_out_of_range();
        test_simultaneous();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
